// File: rtl/avg2x2_alu_seq_if.sv
// ALU micro-op bus between the 2x2 averaging sequencer and the shared ALU.
// The master drives the operation and operands; the slave returns the
// registered ALU result one cycle later.
interface avg2x2_alu_seq_if #(
   parameter int DATA_W = 19
);
   logic [3:0]        alu_op;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_result;

   modport master (
      output alu_op,
      output alu_a,
      output alu_b,
      input  alu_result
   );

   modport slave (
      input  alu_op,
      input  alu_a,
      input  alu_b,
      output alu_result
   );
endinterface

// File: rtl/avg2x2_alu_seq.sv
// avg2x2_alu_seq: sequences the shared ALU to produce the mean of a 2x2 pixel
// window, (p0+p1+p2+p3)>>2, by chaining the registered ALU result back in as
// operand A.
// Build option: define AVG_ROUND_EN to insert an ADDI +2 step before the
// shift, giving round-half-up instead of truncation (one extra cycle).
`ifndef ADDR
`define ADDR 4'h1
`endif
`ifndef ADDI
`define ADDI 4'h2
`endif
`ifndef SHR
`define SHR 4'h7
`endif

module avg2x2_alu_seq #(
   parameter int         PIX_W  = 8,
   parameter int         DATA_W = 19,
   parameter logic [3:0] NOP_OP = 4'hF
) (
   input  logic                     clk,
   input  logic                     RST,
   input  logic                     i_start,
   input  logic [PIX_W-1:0]         i_p0,
   input  logic [PIX_W-1:0]         i_p1,
   input  logic [PIX_W-1:0]         i_p2,
   input  logic [PIX_W-1:0]         i_p3,
   avg2x2_alu_seq_if.master         alu,
   output logic                     o_busy,
   output logic                     o_done,
   output logic [PIX_W-1:0]         o_avg_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADD01,
      S_ADD2,
      S_ADD3,
`ifdef AVG_ROUND_EN
      S_RND,
`endif
      S_SHR,
      S_WB
   } state_t;

   localparam logic [DATA_W-1:0] SHIFT_TWO = DATA_W'(2);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [PIX_W-1:0]   r_p0;
   logic [PIX_W-1:0]   r_p1;
   logic [PIX_W-1:0]   r_p2;
   logic [PIX_W-1:0]   r_p3;
   logic               r_busy;
   logic               r_done;
   logic [PIX_W-1:0]   r_avg;
   logic [3:0]         w_op;
   logic [DATA_W-1:0]  w_a;
   logic [DATA_W-1:0]  w_b;

   // Pixels enter the ALU zero-extended; the sum of four never exceeds DATA_W.
   function automatic logic [DATA_W-1:0] zext(input logic [PIX_W-1:0] pix);
      return {{(DATA_W-PIX_W){1'b0}}, pix};
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and ALU micro-op selection; each non-idle state issues one op.
   always_comb begin
      w_state_nxt = r_state;
      w_op        = NOP_OP;
      w_a         = '0;
      w_b         = '0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt = S_ADD01;
            end
         end
         S_ADD01: begin
            w_op        = `ADDR;
            w_a         = zext(r_p0);
            w_b         = zext(r_p1);
            w_state_nxt = S_ADD2;
         end
         S_ADD2: begin
            w_op        = `ADDR;
            w_a         = alu.alu_result;
            w_b         = zext(r_p2);
            w_state_nxt = S_ADD3;
         end
         S_ADD3: begin
            w_op        = `ADDR;
            w_a         = alu.alu_result;
            w_b         = zext(r_p3);
`ifdef AVG_ROUND_EN
            w_state_nxt = S_RND;
`else
            w_state_nxt = S_SHR;
`endif
         end
`ifdef AVG_ROUND_EN
         S_RND: begin
            w_op        = `ADDI;
            w_a         = alu.alu_result;
            w_b         = SHIFT_TWO;
            w_state_nxt = S_SHR;
         end
`endif
         S_SHR: begin
            w_op        = `SHR;
            w_a         = alu.alu_result;
            w_b         = SHIFT_TWO;
            w_state_nxt = S_WB;
         end
         S_WB: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign alu.alu_op = w_op;
   assign alu.alu_a  = w_a;
   assign alu.alu_b  = w_b;

   // Window capture, status flags and result writeback.
   always_ff @(posedge clk) begin
      if (RST) begin
         r_p0   <= '0;
         r_p1   <= '0;
         r_p2   <= '0;
         r_p3   <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_avg  <= '0;
      end else begin
         if (r_state == S_IDLE && i_start) begin
            r_p0 <= i_p0;
            r_p1 <= i_p1;
            r_p2 <= i_p2;
            r_p3 <= i_p3;
         end
         r_busy <= (w_state_nxt != S_IDLE);
         r_done <= (r_state == S_WB);
         if (r_state == S_WB) begin
            // The shifted mean is at most 2^PIX_W-1, so truncation is lossless.
            r_avg <= alu.alu_result[PIX_W-1:0];
         end
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_avg_out = r_avg;

endmodule

// File: tb/tb_avg2x2_alu_seq.sv
// Testbench for avg2x2_alu_seq: a behavioural registered ALU closes the loop,
// directed windows push expected averages and done cycles into a queue, and a
// monitor pops and compares on every done pulse.
`timescale 1ns/1ps
`ifndef ADDR
`define ADDR 4'h1
`endif
`ifndef ADDI
`define ADDI 4'h2
`endif
`ifndef SHR
`define SHR 4'h7
`endif

module tb_avg2x2_alu_seq;
   localparam int         PIX_W  = 8;
   localparam int         DATA_W = 19;
   localparam logic [3:0] NOP_OP = 4'hF;
`ifdef AVG_ROUND_EN
   localparam int LAT = 6;
   localparam int RND = 1;
`else
   localparam int LAT = 5;
   localparam int RND = 0;
`endif

   logic             clk = 1'b0;
   logic             RST;
   logic             i_start;
   logic [PIX_W-1:0] i_p0, i_p1, i_p2, i_p3;
   logic             o_busy, o_done;
   logic [PIX_W-1:0] o_avg_out;

   avg2x2_alu_seq_if #(.DATA_W(DATA_W)) alu_if ();

   avg2x2_alu_seq #(.PIX_W(PIX_W), .DATA_W(DATA_W), .NOP_OP(NOP_OP)) dut (
      .clk       (clk),
      .RST       (RST),
      .i_start   (i_start),
      .i_p0      (i_p0),
      .i_p1      (i_p1),
      .i_p2      (i_p2),
      .i_p3      (i_p3),
      .alu       (alu_if.master),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_avg_out (o_avg_out)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] alu_model(input logic [3:0] op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
      case (op)
         `ADDR:   return a + b;
         `ADDI:   return a + b;
         `SHR:    return a >> b;
         default: return '0;
      endcase
   endfunction

   always @(posedge clk) alu_if.alu_result <= alu_model(alu_if.alu_op, alu_if.alu_a, alu_if.alu_b);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int avg;
      int cyc;
   } exp_t;
   exp_t exp_q[$];

   int n_chk = 0;
   int n_pass = 0;
   int done_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (o_done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_done: got avg_out %0d expected no done (cycle %0d)", o_avg_out, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("avg_out", 32'(o_avg_out), e.avg);
            chk("done_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic drive(input int a, input int b, input int c, input int d);
      i_p0 = PIX_W'(a);
      i_p1 = PIX_W'(b);
      i_p2 = PIX_W'(c);
      i_p3 = PIX_W'(d);
   endtask

   // Issue one window at the current negedge and push its expectation.
   task automatic issue(input int a, input int b, input int c, input int d, input int avg);
      exp_t e;
      drive(a, b, c, d);
      i_start = 1'b1;
      e.avg = avg;
      e.cyc = cyc + 1 + LAT;
      exp_q.push_back(e);
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
      while (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_chk++;
         $display("FAIL done_timeout: got no done expected avg_out %0d by cycle %0d", e.avg, e.cyc);
      end
   endtask

   int bc;
   int dc0;

   initial begin
      RST = 1'b1;
      i_start = 1'b0;
      drive(0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_avg", 32'(o_avg_out), 0);
      chk("rst_op", 32'(alu_if.alu_op), 32'(NOP_OP));
      chk("rst_a", alu_if.alu_a, 0);
      chk("rst_b", alu_if.alu_b, 0);
      RST = 1'b0;
      @(negedge clk);

      // Basic average with micro-op trace.
      issue(10, 20, 30, 40, 25);
      bc = int'(o_busy);
      chk("b_op1", 32'(alu_if.alu_op), 32'(`ADDR));
      chk("b_a1", alu_if.alu_a, 10);
      chk("b_b1", alu_if.alu_b, 20);
      @(negedge clk); bc += int'(o_busy);
      chk("b_op2", 32'(alu_if.alu_op), 32'(`ADDR));
      chk("b_a2", alu_if.alu_a, 30);
      chk("b_b2", alu_if.alu_b, 30);
      @(negedge clk); bc += int'(o_busy);
      chk("b_op3", 32'(alu_if.alu_op), 32'(`ADDR));
      chk("b_a3", alu_if.alu_a, 60);
      chk("b_b3", alu_if.alu_b, 40);
`ifdef AVG_ROUND_EN
      @(negedge clk); bc += int'(o_busy);
      chk("b_op_rnd", 32'(alu_if.alu_op), 32'(`ADDI));
      chk("b_a_rnd", alu_if.alu_a, 100);
      chk("b_b_rnd", alu_if.alu_b, 2);
`endif
      @(negedge clk); bc += int'(o_busy);
      chk("b_op_shr", 32'(alu_if.alu_op), 32'(`SHR));
      chk("b_a_shr", alu_if.alu_a, 100 + 2 * RND);
      chk("b_b_shr", alu_if.alu_b, 2);
      @(negedge clk); bc += int'(o_busy);
      chk("b_op_wb", 32'(alu_if.alu_op), 32'(NOP_OP));
      @(negedge clk);
      chk("b_done_now", 32'(o_done), 1);
      chk("b_busy_done", 32'(o_busy), 0);
      chk("b_busy_cycles", bc, LAT);
      repeat (4) @(negedge clk);
      chk("b_avg_hold", 32'(o_avg_out), 25);
      chk("b_done_low", 32'(o_done), 0);

      // Rounding behaviour, then the all-ones bound.
      issue(1, 2, 2, 2, 1 + RND);
      drain();
      issue(255, 255, 255, 255, 255);
      drain();

      // Start while busy is ignored.
      dc0 = done_cnt;
      issue(10, 10, 10, 10, 10);
      drive(0, 0, 0, 0);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      drain();
      repeat (10) @(negedge clk);
      chk("busy_start_dones", done_cnt - dc0, 1);
      chk("busy_start_avg", 32'(o_avg_out), 10);

      // Back-to-back with start held high.
      begin
         exp_t e;
         drive(4, 4, 4, 4);
         i_start = 1'b1;
         e.avg = 4; e.cyc = cyc + 1 + LAT;
         exp_q.push_back(e);
         e.avg = 8; e.cyc = cyc + 2 + 2 * LAT;
         exp_q.push_back(e);
         @(negedge clk);
         drive(8, 8, 8, 8);
         repeat (LAT + 1) @(negedge clk);
         i_start = 1'b0;
         drain();
      end

      // Reset in ADD3 aborts the window.
      dc0 = done_cnt;
      drive(50, 51, 52, 53);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("r_add3_b", alu_if.alu_b, 53);
      RST = 1'b1;
      @(negedge clk);
      RST = 1'b0;
      chk("r_busy", 32'(o_busy), 0);
      chk("r_done", 32'(o_done), 0);
      chk("r_avg", 32'(o_avg_out), 0);
      chk("r_op", 32'(alu_if.alu_op), 32'(NOP_OP));
      chk("r_a", alu_if.alu_a, 0);
      repeat (12) @(negedge clk);
      chk("r_no_done", done_cnt - dc0, 0);
      issue(100, 100, 100, 100, 100);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected completion");
      $fatal(1);
   end
endmodule
